// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit producing a {hi, lo} result.
// State | meaning: IDLE | waiting for start; RUN | one multiply/divide step per cycle; FINISH | done pulse, result valid.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 is_div, sign_a, sign_b;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   work;

  logic                 accept, in_div, in_neg_a, in_neg_b, div_zero, single;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   fast_mag, fast_prod;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   step_next, mul_res;
  logic [WIDTH-1:0]     res_hi, res_lo;

  always_comb begin
    in_div   = op[1];
    in_neg_a = ~op[0] & a[WIDTH-1];
    in_neg_b = ~op[0] & b[WIDTH-1];
    mag_a    = in_neg_a ? -a : a;
    mag_b    = in_neg_b ? -b : b;
    div_zero = in_div && (b == '0);
    single   = div_zero || (!in_div && FAST_MUL);
    accept   = (state == S_IDLE) && start && !cancel;
    fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    fast_prod = (in_neg_a ^ in_neg_b) ? -fast_mag : fast_mag;
  end

  // Shared work register: multiply keeps {acc, multiplier}, divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (is_div)
      step_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
    else
      step_next = {mul_sum, work[WIDTH-1:1]};
    mul_res = (sign_a ^ sign_b) ? -step_next : step_next;
    if (is_div) begin
      res_lo = (sign_a ^ sign_b) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
      res_hi = sign_a ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = mul_res[WIDTH-1:0];
      res_hi = mul_res[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = single ? S_FINISH : S_RUN;
      S_RUN:    if (cancel) state_nxt = S_IDLE;
                else if (cnt == '0) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      work   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      is_div <= in_div;
      sign_a <= in_neg_a;
      sign_b <= in_neg_b;
      opnd   <= in_div ? mag_b : mag_a;
      work   <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
      cnt    <= CW'(WIDTH - 1);
      if (div_zero) begin
        hi <= a;
        lo <= '1;
      end else if (single) begin
        hi <= fast_prod[2*WIDTH-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
      end
    end else if (state == S_RUN && !cancel) begin
      work <= step_next;
      if (cnt == '0) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: iterative instance (dut0) and single-cycle multiply instance (dut1).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, start_f, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy0, done0, busy1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;
  int          cmp = 0;
  int          errs = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start_f), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the first idle cycle after done.
  task automatic do_op(input bit fast, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input int lat, input logic [31:0] eh, input logic [31:0] el, input string tag);
    int n;
    op = o; a = va; b = vb;
    if (fast) start_f = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_f = 1'b0;
    chk({tag, "_busy"}, fast ? busy1 : busy0, (lat > 1) ? 64'd1 : 64'd0);
    n = 1;
    while (!(fast ? done1 : done0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_hi"}, fast ? hi1 : hi0, eh);
    chk({tag, "_lo"}, fast ? lo1 : lo0, el);
    @(negedge clk);
    chk({tag, "_done_end"}, fast ? done1 : done0, 0);
  endtask

  initial begin
    int n, ndone, lat_seen;
    logic [63:0] res_seen;
    rst = 1'b1; start = 1'b0; start_f = 1'b0; cancel = 1'b0; op = MULT; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_hilo", {hi0, lo0}, 64'd0);
    chk("rst_fast_hilo", {busy1, done1, hi1, lo1}, 0);

    do_op(0, MULT,  32'hFFFFFFFD, 32'd5,        33, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    do_op(1, MULT,  32'hFFFFFFFD, 32'd5,        1,  32'hFFFFFFFF, 32'hFFFFFFF1, "mult_fast");
    do_op(1, MULT,  32'd7,        32'hFFFFFFFF, 1,  32'hFFFFFFFF, 32'hFFFFFFF9, "mult_fast2");
    do_op(0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    do_op(0, MULT,  32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, "mult_minmin");
    do_op(0, DIVU,  32'd100,      32'd7,        33, 32'd2,        32'd14,       "divu");
    do_op(0, DIV,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    do_op(0, DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, "div_ovf");
    do_op(0, DIVU,  32'h1234,     32'd0,        1,  32'h1234,     32'hFFFFFFFF, "divu_zero");
    do_op(0, DIV,   32'hFFFFFFFB, 32'd0,        1,  32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero_neg");
    do_op(0, DIV,   32'd7,        32'hFFFFFFFE, 33, 32'd1,        32'hFFFFFFFD, "div_negb");

    // cancel at T+10, new request at T+11
    op = DIVU; a = 32'd50; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", busy0, 0);
    chk("cancel_done", done0, 0);
    chk("cancel_hilo_kept", {hi0, lo0}, {32'd1, 32'hFFFFFFFD});
    do_op(0, DIVU, 32'd50, 32'd3, 33, 32'd2, 32'd16, "after_cancel");

    // start pulsed at T+5 while busy must be ignored
    op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) @(negedge clk);
    n += 4;
    op = DIVU; a = 32'd9; b = 32'd0; start = 1'b1;
    ndone = 0; lat_seen = 0; res_seen = '0;
    while (n < 45) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done0) begin
        ndone++;
        lat_seen = n;
        res_seen = {hi0, lo0};
      end
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_lat", lat_seen, 33);
    chk("busy_start_res", res_seen, 64'd42);

    // start with cancel in idle: dropped
    op = DIVU; a = 32'd1; b = 32'd0; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", busy0, 0);
    chk("start_cancel_done", done0, 0);
    @(negedge clk);
    chk("start_cancel_done2", done0, 0);
    chk("start_cancel_hilo", {hi0, lo0}, 64'd42);

    // start sampled during the done cycle is ignored
    op = MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_start_lat", n, 33);
    op = DIVU; a = 32'd5; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", busy0, 0);
    chk("done_start_done", done0, 0);
    chk("done_start_hilo", {hi0, lo0}, 64'd9);
    @(negedge clk);
    chk("done_start_done2", done0, 0);

    // rst mid-operation at T+20
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_hilo", {hi0, lo0}, 64'd0);
    do_op(0, DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
